// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   rx_state_t              receiver FSM states (PARITY is used only when
//                           UART_RX_PARITY_EN is defined)
//   DEFAULT_CLOCKS_PER_BAUD 25 MHz / 115200
//   UART_DATA_BITS          data bits per frame
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd217;
    localparam int          UART_DATA_BITS          = 8;

endpackage

// File: rtl/rx_uart_if.sv
// rx_uart_if: receive-side result bus of the UART receiver.
//   o_wr          one-cycle strobe, o_data holds a valid byte
//   o_data        received byte, held until the next o_wr
//   o_frame_err   one-cycle strobe, stop bit sampled low
//   o_busy        receiver is inside a frame
//   o_parity_err  one-cycle strobe alongside o_wr (UART_RX_PARITY_EN only)
// master: the receiver (drives everything); slave: the consumer.
interface rx_uart_if;
    import uart_pkg::*;

    logic                      o_wr;
    logic [UART_DATA_BITS-1:0] o_data;
    logic                      o_frame_err;
    logic                      o_busy;
`ifdef UART_RX_PARITY_EN
    logic                      o_parity_err;
`endif

`ifdef UART_RX_PARITY_EN
    modport master (output o_wr, o_data, o_frame_err, o_busy, o_parity_err);
    modport slave  (input  o_wr, o_data, o_frame_err, o_busy, o_parity_err);
`else
    modport master (output o_wr, o_data, o_frame_err, o_busy);
    modport slave  (input  o_wr, o_data, o_frame_err, o_busy);
`endif

endinterface

// File: rtl/rx_uart_sync.sv
// rx_sync: two-flop synchroniser for an asynchronous input. Both flops reset
// to 1, which is the idle level of a UART line, so a reset never looks like
// a start edge.
//   i_clk      clock
//   i_reset_n  synchronous active-low reset
//   i_d        asynchronous input
//   o_q        synchronised output
module rx_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_r;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) sync_r <= 2'b11;
        else            sync_r <= {sync_r[0], i_d};
    end

    assign o_q = sync_r[1];

endmodule

// File: rtl/rx_uart.sv
// rx_uart: 8N1 serial UART receiver. Synchronises the line, validates the
// start bit at mid-bit, samples each data bit at mid-baud (LSB first) and
// presents the byte with a one-cycle o_wr strobe, or o_frame_err if the stop
// bit reads low.
//   i_clk      clock
//   i_reset_n  synchronous active-low reset
//   i_uart_rx  asynchronous serial line, idle high
//   bus        rx_uart_if.master: o_wr, o_data, o_frame_err, o_busy
//              (+ o_parity_err)
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit between
// bit 7 and the stop bit, reported through o_parity_err.
module rx_uart
    import uart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_uart_rx,
    rx_uart_if.master    bus
);

    // First sample lands mid start bit; all later ones one full bit apart.
    localparam logic [23:0] HALF_M1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
    localparam logic [23:0] FULL_M1 = CLOCKS_PER_BAUD - 24'd1;
    localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    rx_sync u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_uart_rx),
        .o_q       (rx_s)
    );

    rx_state_t                 state_r,    state_nx;
    logic [23:0]               baud_cnt_r, baud_cnt_nx;
    logic [2:0]                bit_cnt_r,  bit_cnt_nx;
    logic [UART_DATA_BITS-1:0] shreg_r,    shreg_nx;
    logic [UART_DATA_BITS-1:0] data_r,     data_nx;
    logic                      wr_r,       wr_nx;
    logic                      ferr_r,     ferr_nx;
    logic                      busy_r;
`ifdef UART_RX_PARITY_EN
    logic                      par_r,      par_nx;
    logic                      perr_r,     perr_nx;
`endif

    logic tick;
    assign tick = (baud_cnt_r == 24'd0);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shreg_r    <= '0;
            data_r     <= '0;
            wr_r       <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r      <= 1'b0;
            perr_r     <= 1'b0;
`endif
        end else begin
            state_r    <= state_nx;
            baud_cnt_r <= baud_cnt_nx;
            bit_cnt_r  <= bit_cnt_nx;
            shreg_r    <= shreg_nx;
            data_r     <= data_nx;
            wr_r       <= wr_nx;
            ferr_r     <= ferr_nx;
            // Registered from next state so it tracks state_r exactly.
            busy_r     <= (state_nx != IDLE);
`ifdef UART_RX_PARITY_EN
            par_r      <= par_nx;
            perr_r     <= perr_nx;
`endif
        end
    end

    always_comb begin
        state_nx    = state_r;
        baud_cnt_nx = baud_cnt_r;
        bit_cnt_nx  = bit_cnt_r;
        shreg_nx    = shreg_r;
        data_nx     = data_r;
        wr_nx       = 1'b0;
        ferr_nx     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nx      = par_r;
        perr_nx     = 1'b0;
`endif

        // Inside a frame the counter free-runs, reloading at each sample.
        if (state_r != IDLE)
            baud_cnt_nx = tick ? FULL_M1 : baud_cnt_r - 24'd1;

        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_nx    = START;
                    baud_cnt_nx = HALF_M1;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_nx = IDLE;    // glitch, not a real start bit
                    end else begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nx   = {rx_s, shreg_r[UART_DATA_BITS-1:1]};
                    bit_cnt_nx = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_nx   = rx_s;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge in.
                if (tick) begin
                    state_nx = IDLE;
                    if (rx_s) begin
                        wr_nx   = 1'b1;
                        data_nx = shreg_r;
`ifdef UART_RX_PARITY_EN
                        perr_nx = (^shreg_r) ^ par_r;
`endif
                    end else begin
                        ferr_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.o_wr        = wr_r;
    assign bus.o_data      = data_r;
    assign bus.o_frame_err = ferr_r;
    assign bus.o_busy      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = perr_r;
`endif

endmodule
